regfile_sb: RTL and testbench

- Architectural integer register file, 32 x 32-bit. It is the consumer end of the writeback interface driven by the MEM/WB pipeline register.
- Accepts one write per cycle from WB.
- Serves two combinational read ports to the ID stage, with same-cycle WB bypass.
- Carries a per-register pending-write scoreboard so ID can detect RAW hazards on results still in flight.

---
 rtl/regfile_sb_pkg.sv | 29 ++
 rtl/regfile_read_port.sv | 38 +++
 rtl/regfile_sb.sv | 112 +++++++++++
 tb/tb_regfile_sb.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_sb_pkg.sv
// Shared register-file types and the scoreboard counter step function.
// The pending-write scoreboard is only built when REGFILE_SCOREBOARD_EN is defined.
package regfile_sb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NREGS_DEF  = 32;

  typedef logic [ADDR_W_DEF-1:0] RegAddrBus;
  typedef logic [DATA_W_DEF-1:0] RegBus;
  typedef logic [1:0]            SbCntBus;

  localparam RegBus     ZeroWord   = '0;
  localparam RegAddrBus NOPRegAddr = '0;
  localparam logic      True       = 1'b1;
  localparam logic      False      = 1'b0;

  localparam SbCntBus SB_CNT_MAX = 2'd3;

  // Saturating step: a simultaneous issue and retire on one register cancel out.
  function automatic SbCntBus sb_next(input SbCntBus cur, input logic inc, input logic dec);
    SbCntBus nxt;
    nxt = cur;
    if (inc && !dec && cur != SB_CNT_MAX) nxt = cur + 2'd1;
    if (dec && !inc && cur != 2'd0)       nxt = cur - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: x0/enable masking, write-first WB bypass and
// the RAW busy flag computed from the count left after a same-cycle retire.
module regfile_read_port
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] reg_data,
  input  SbCntBus           cnt,
  input  logic              wb_w_req,
  input  logic [ADDR_W-1:0] wb_w_addr,
  input  logic [DATA_W-1:0] wb_w_data,
  input  logic              dec,
  output logic [DATA_W-1:0] data,
  output logic              busy
);

  logic active;
  logic wb_hit;
  logic retire_hit;

  assign active     = !rst && req && (addr != '0);
  assign wb_hit     = wb_w_req && (wb_w_addr == addr);
  assign retire_hit = dec && wb_hit;

  always_comb begin
    data = '0;
    if (active) data = wb_hit ? wb_w_data : reg_data;
  end

  // Busy only if something is still pending once this cycle's retire is taken out.
  assign busy = active && (cnt > {1'b0, retire_hit});

endmodule

// File: rtl/regfile_sb.sv
// 32x32 integer register file with WB bypass and optional per-register
// pending-write scoreboard (enabled by defining REGFILE_SCOREBOARD_EN).
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 32   // must equal 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              wb_w_req,
  input  logic [ADDR_W-1:0] wb_w_addr,
  input  logic [DATA_W-1:0] wb_w_data,
  input  logic              r1_req,
  input  logic [ADDR_W-1:0] r1_addr,
  output logic [DATA_W-1:0] r1_data,
  output logic              r1_busy,
  input  logic              r2_req,
  input  logic [ADDR_W-1:0] r2_addr,
  output logic [DATA_W-1:0] r2_data,
  output logic              r2_busy,
  input  logic              iss_req,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic              flush
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic              wr_en;
  SbCntBus           r1_cnt;
  SbCntBus           r2_cnt;

  assign wr_en = rdy && wb_w_req && (wb_w_addr != '0);

  // Entry 0 never matches wr_en, so x0 stays at its reset value.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_en && (wb_w_addr == ADDR_W'(i))) regs_d[i] = wb_w_data;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (rst) regs_q[i] <= '0;
      else     regs_q[i] <= regs_d[i];
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  SbCntBus cnt_q [NREGS];
  SbCntBus cnt_d [NREGS];
  logic    inc;

  assign inc = rdy && iss_req && (iss_addr != '0);

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      if (rdy && flush) cnt_d[i] = '0;
      else cnt_d[i] = sb_next(cnt_q[i],
                              inc && (iss_addr == ADDR_W'(i)),
                              wr_en && (wb_w_addr == ADDR_W'(i)));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (rst) cnt_q[i] <= '0;
      else     cnt_q[i] <= cnt_d[i];
    end
  end

  assign r1_cnt = cnt_q[r1_addr];
  assign r2_cnt = cnt_q[r2_addr];
`else
  logic unused_sb_inputs;
  assign unused_sb_inputs = &{1'b0, iss_req, iss_addr, flush, True, False};
  assign r1_cnt = '0;
  assign r2_cnt = '0;
`endif

  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
    .rst       (rst),
    .req       (r1_req),
    .addr      (r1_addr),
    .reg_data  (regs_q[r1_addr]),
    .cnt       (r1_cnt),
    .wb_w_req  (wb_w_req),
    .wb_w_addr (wb_w_addr),
    .wb_w_data (wb_w_data),
    .dec       (wr_en),
    .data      (r1_data),
    .busy      (r1_busy)
  );

  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd2 (
    .rst       (rst),
    .req       (r2_req),
    .addr      (r2_addr),
    .reg_data  (regs_q[r2_addr]),
    .cnt       (r2_cnt),
    .wb_w_req  (wb_w_req),
    .wb_w_addr (wb_w_addr),
    .wb_w_data (wb_w_data),
    .dec       (wr_en),
    .data      (r2_data),
    .busy      (r2_busy)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios then random traffic,
// all outputs compared against a behavioural register/scoreboard model.
module tb_regfile_sb;

`ifdef REGFILE_SCOREBOARD_EN
  localparam bit SB_EN = 1'b1;
`else
  localparam bit SB_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        wb_w_req;
  logic [4:0]  wb_w_addr;
  logic [31:0] wb_w_data;
  logic        r1_req, r2_req;
  logic [4:0]  r1_addr, r2_addr;
  logic [31:0] r1_data, r2_data;
  logic        r1_busy, r2_busy;
  logic        iss_req;
  logic [4:0]  iss_addr;
  logic        flush;

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .wb_w_req  (wb_w_req),
    .wb_w_addr (wb_w_addr),
    .wb_w_data (wb_w_data),
    .r1_req    (r1_req),
    .r1_addr   (r1_addr),
    .r1_data   (r1_data),
    .r1_busy   (r1_busy),
    .r2_req    (r2_req),
    .r2_addr   (r2_addr),
    .r2_data   (r2_data),
    .r2_busy   (r2_busy),
    .iss_req   (iss_req),
    .iss_addr  (iss_addr),
    .flush     (flush)
  );

  logic [31:0] m_regs [32];
  int          m_cnt  [32];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input logic req, input logic [4:0] a);
    if (rst || !req || a == 0) return 32'h0;
    if (wb_w_req && wb_w_addr == a) return wb_w_data;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic req, input logic [4:0] a);
    int left;
    if (!SB_EN || rst || !req || a == 0) return 1'b0;
    left = m_cnt[a];
    if (rdy && wb_w_req && wb_w_addr == a && left > 0) left = left - 1;
    return left > 0;
  endfunction

  task automatic check_outs();
    #1;
    chk("r1_data", r1_data, exp_data(r1_req, r1_addr));
    chk("r1_busy", {31'b0, r1_busy}, {31'b0, exp_busy(r1_req, r1_addr)});
    chk("r2_data", r2_data, exp_data(r2_req, r2_addr));
    chk("r2_busy", {31'b0, r2_busy}, {31'b0, exp_busy(r2_req, r2_addr)});
  endtask

  // Advance one clock and apply the architectural update rules to the model.
  task automatic tick();
    int ia, da;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = 32'h0;
        m_cnt[i]  = 0;
      end
    end else if (rdy) begin
      if (wb_w_req && wb_w_addr != 0) m_regs[wb_w_addr] = wb_w_data;
      if (SB_EN) begin
        if (flush) begin
          for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        end else begin
          ia = (iss_req && iss_addr != 0) ? int'(iss_addr) : -1;
          da = (wb_w_req && wb_w_addr != 0) ? int'(wb_w_addr) : -2;
          if (ia > 0 && ia != da && m_cnt[ia] < 3) m_cnt[ia]++;
          if (da > 0 && ia != da && m_cnt[da] > 0) m_cnt[da]--;
        end
      end
    end
    #1;
  endtask

  task automatic step();
    check_outs();
    tick();
  endtask

  task automatic idle();
    rst = 1'b0; rdy = 1'b1;
    wb_w_req = 1'b0; wb_w_addr = '0; wb_w_data = '0;
    r1_req = 1'b0; r1_addr = '0; r2_req = 1'b0; r2_addr = '0;
    iss_req = 1'b0; iss_addr = '0; flush = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'h0;
      m_cnt[i]  = 0;
    end
    idle();
    rst = 1'b1; r1_req = 1'b1; r1_addr = 5'd3; r2_req = 1'b1; r2_addr = 5'd31;
    wb_w_req = 1'b1; wb_w_addr = 5'd3; wb_w_data = 32'h1111_2222;
    step();
    step();
    $display("reset phase done");

    // Reset contents on every index.
    idle();
    r1_req = 1'b1; r2_req = 1'b1;
    for (int a = 1; a < 32; a++) begin
      r1_addr = 5'(a); r2_addr = 5'(32 - a);
      step();
    end
    $display("post-reset sweep done");

    // x0 writes are dropped.
    idle();
    wb_w_req = 1'b1; wb_w_addr = 5'd0; wb_w_data = 32'hDEAD_BEEF;
    r1_req = 1'b1; r1_addr = 5'd0;
    step();
    idle();
    r1_req = 1'b1; r1_addr = 5'd0;
    check_outs();
    chk("x0_reads_zero", r1_data, 32'h0);
    tick();
    $display("x0 write/read done");

    // Same-cycle bypass, then storage.
    idle();
    wb_w_req = 1'b1; wb_w_addr = 5'd5; wb_w_data = 32'h1234_5678;
    r1_req = 1'b1; r1_addr = 5'd5;
    check_outs();
    chk("bypass_x5", r1_data, 32'h1234_5678);
    tick();
    wb_w_req = 1'b0;
    check_outs();
    chk("stored_x5", r1_data, 32'h1234_5678);
    tick();
    $display("x5 bypass/storage done");

    // Four issues to x7 saturate, three retires drain it.
    idle();
    iss_req = 1'b1; iss_addr = 5'd7; r2_req = 1'b1; r2_addr = 5'd7;
    repeat (4) step();
    iss_req = 1'b0; wb_w_req = 1'b1; wb_w_addr = 5'd7;
    for (int k = 0; k < 3; k++) begin
      wb_w_data = $urandom;
      step();
    end
    wb_w_req = 1'b0;
    step();
    $display("x7 saturation/drain done");

    // Issue and retire to x9 in the same cycle with one already pending.
    idle();
    iss_req = 1'b1; iss_addr = 5'd9; r1_req = 1'b1; r1_addr = 5'd9;
    step();
    wb_w_req = 1'b1; wb_w_addr = 5'd9; wb_w_data = 32'h0909_0909;
    step();
    iss_req = 1'b0; wb_w_req = 1'b0;
    step();
    $display("x9 inc+dec done");

    // Flush clears counts; a late retire must not underflow.
    idle();
    r1_req = 1'b1; r1_addr = 5'd3; r2_req = 1'b1; r2_addr = 5'd4;
    iss_req = 1'b1; iss_addr = 5'd3; step();
    iss_addr = 5'd4; step();
    iss_req = 1'b0; flush = 1'b1; step();
    flush = 1'b0; wb_w_req = 1'b1; wb_w_addr = 5'd3; wb_w_data = 32'hCAFE_F00D; step();
    wb_w_req = 1'b0;
    check_outs();
    chk("x3_after_flush", r1_data, 32'hCAFE_F00D);
    tick();
    $display("flush scenario done");

    // Stall: nothing commits, but the bypass is still visible.
    idle();
    rdy = 1'b0; wb_w_req = 1'b1; wb_w_addr = 5'd10; wb_w_data = 32'hA5A5_A5A5;
    iss_req = 1'b1; iss_addr = 5'd10; r1_req = 1'b1; r1_addr = 5'd10;
    r2_req = 1'b1; r2_addr = 5'd10;
    check_outs();
    chk("stall_bypass", r1_data, 32'hA5A5_A5A5);
    tick();
    idle();
    r1_req = 1'b1; r1_addr = 5'd10; r2_req = 1'b1; r2_addr = 5'd10;
    check_outs();
    chk("stall_no_write", r1_data, 32'h0);
    tick();
    $display("stall scenario done");

    // Random traffic concentrated on a few registers to provoke collisions.
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 79) == 0);
      rdy       = ($urandom_range(0, 7) != 0);
      wb_w_req  = ($urandom_range(0, 2) != 0);
      wb_w_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      wb_w_data = $urandom;
      iss_req   = ($urandom_range(0, 1) != 0);
      iss_addr  = 5'($urandom_range(0, 7));
      flush     = ($urandom_range(0, 29) == 0);
      r1_req    = ($urandom_range(0, 5) != 0);
      r1_addr   = 5'($urandom_range(0, 7));
      r2_req    = ($urandom_range(0, 5) != 0);
      r2_addr   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      step();
    end
    $display("random phase done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
